spi_frame_sequencer: RTL and testbench
======================================

// Module: spi_frame_sequencer
// PURPOSE
// Sits between counter/button logic and spi_master_top on the master side. Snapshots
// {runstop, clear, counter} on change or request, then sequences one 3-byte SPI frame:
// drives tx byte + start pulse per byte, waits on master done, frames the transfer with
// active-low ss_n, enforces inter-frame gap, aborts on done timeout.
// PARAMETERS
// CNT_W        14      counter width (max 14; bits above 13 unused)
// SETUP_CYC    2       clk cycles ss_n low before first start pulse
// GAP_CYC      4       clk cycles ss_n high after frame before next frame may begin
// TIMEOUT_CYC  1024    clk cycles to wait for i_done per byte before abort
// PORTS
// clk          in   1      system clock, all logic on rising edge
// reset        in   1      asynchronous, active-low (0 = reset)
// i_counter    in   CNT_W  live up-counter value
// i_runstop    in   1      run/stop mode level
// i_clear      in   1      clear request level
// i_force      in   1      1-cycle pulse: send frame even if unchanged
// i_ready      in   1      spi master idle, may accept start
// i_done       in   1      1-cycle pulse: master finished current byte
// o_tx_data    out  8      byte presented to master; stable from start until done
// o_start      out  1      1-cycle pulse launching one byte
// o_ss_n       out  1      frame select, active-low
// o_busy       out  1      1 while state != IDLE
// o_err        out  1      sticky timeout flag; cleared only by reset or next good frame end
// BEHAVIOUR
// Reset: state IDLE, o_tx_data=0, o_start=0, o_ss_n=1, o_busy=0, o_err=0, last_sent=all 1s,
//   pending=0, byte_idx=0, counters 0. First snapshot after reset therefore always differs.
// Trigger: pending set when i_force=1, or {i_runstop,i_clear,i_counter} != last_sent.
//   Trigger during non-IDLE state sets pending; serviced after GAP. Multiple events merge.
// Snapshot: taken on IDLE->SETUP transition; frame content frozen for whole frame;
//   last_sent <= snapshot at same edge; pending cleared at same edge unless a new event hits.
// Frame bytes: B0 = {6'b101000, runstop, clear}; B1 = {2'b00, cnt[13:8]}; B2 = cnt[7:0]
//   (cnt zero-extended to 14 bits when CNT_W<14).
// FSM:
//   IDLE    : pending -> SETUP (ss_n<=0, snapshot).
//   SETUP   : count SETUP_CYC cycles -> LOAD.
//   LOAD    : wait i_ready=1; then o_tx_data<=B[byte_idx], o_start=1 for exactly 1 cycle -> WAIT.
//   WAIT    : i_done -> byte_idx==2 ? HOLD : (byte_idx++, LOAD). Timeout counter reset on entry;
//             reaching TIMEOUT_CYC-1 without i_done -> o_err<=1, ABORT.
//   HOLD    : 1 cycle, ss_n<=1, o_err<=0 (successful frame) -> GAP.
//   ABORT   : ss_n<=1, byte_idx<=0, last_sent<=all 1s (forces resend) -> GAP.
//   GAP     : count GAP_CYC cycles with ss_n=1 -> IDLE.
// Latency: force pulse in IDLE -> ss_n low next edge; first o_start SETUP_CYC+1 cycles later
//   if i_ready=1. Min frame-to-frame ss_n high time = GAP_CYC+1 cycles.
// i_done outside WAIT ignored. i_done same cycle as timeout expiry: done wins, no error.
// o_start never asserted while ss_n=1 or i_ready=0. byte_idx never exceeds 2.
// Reset mid-frame: immediate return to reset values; ss_n high asynchronously.
// TESTING
// 1 Release reset, counter=0x0123, runstop=1, clear=0, ready=1, done 8 clk after each start
//   -> ss_n low, bytes 0xA2, 0x01, 0x23 in order, 3 start pulses, ss_n high, o_err=0.
// 2 Hold inputs constant after frame 1, no force -> no further ss_n/start activity for 500 clk;
//   then i_force pulse -> identical frame resent.
// 3 Counter changes 0x0123->0x0124 while byte 1 in flight -> current frame keeps 0x23 as B2;
//   second frame follows with B2=0x24 after exactly GAP_CYC+1 high cycles.
// 4 Master never returns done on byte 1 -> o_err=1 at TIMEOUT_CYC cycles, ss_n high, GAP,
//   auto resend of full frame; next good frame clears o_err.
// 5 i_ready held low 20 cycles in LOAD -> no start until ready=1; o_tx_data stable through WAIT.
// 6 Assert reset (0) during WAIT of byte 2 -> ss_n=1, start=0, busy=0 same cycle;
//   after release, fresh frame from B0.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//   Sits in front of an SPI master. Snapshots {runstop, clear, counter} when it
//   changes or when a resend is forced, then plays that snapshot out as one
//   3-byte frame framed by an active-low slave select. Enforces a setup time
//   before the first byte, an inter-frame gap, and aborts a frame when the
//   master never reports a byte as done.
//
//   Frame bytes: B0 = {6'b101000, runstop, clear}
//                B1 = {2'b00, cnt[13:8]}
//                B2 = cnt[7:0]   (cnt zero-extended to 14 bits)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   i_counter  live counter value (CNT_W bits)
//   i_runstop  run/stop level
//   i_clear    clear request level
//   i_force    1-cycle pulse: send a frame even if nothing changed
//   i_ready    master idle, a start may be issued
//   i_done     1-cycle pulse: master finished the current byte
//   o_tx_data  byte for the master, held from its start pulse until done
//   o_start    1-cycle start pulse for one byte
//   o_ss_n     frame select, active low
//   o_busy     high whenever the sequencer is not idle
//   o_err      sticky done-timeout flag, cleared by reset or a completed frame
//   dbg_state  current FSM state encoding
//
// Handshake: a byte is launched by o_start only after i_ready was seen high
// in LOAD; o_tx_data stays constant until the matching i_done pulse. i_done
// is only honoured while waiting for a byte.
module spi_frame_sequencer #(
   parameter int CNT_W       = 14,
   parameter int SETUP_CYC   = 2,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] i_counter,
   input  logic             i_runstop,
   input  logic             i_clear,
   input  logic             i_force,
   input  logic             i_ready,
   input  logic             i_done,
   output logic [7:0]       o_tx_data,
   output logic             o_start,
   output logic             o_ss_n,
   output logic             o_busy,
   output logic             o_err,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LOAD  = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4,
      S_ABORT = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   localparam int SW = CNT_W + 2;
   // One shared counter serves setup, timeout and gap timing.
   localparam int CW = $clog2(TIMEOUT_CYC + SETUP_CYC + GAP_CYC + 1);

   state_t        state_q, state_d;
   logic [SW-1:0] last_q, last_d;
   logic          pending_q, pending_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   snap_q, snap_d;   // {runstop, clear, cnt[13:0]}
   logic [7:0]    tx_d;
   logic          start_d, ss_n_d, err_d;

   logic [SW-1:0] cur;
   logic [13:0]   cur_cnt14;
   logic          trig_evt;
   logic [7:0]    cur_byte;

   assign cur       = {i_runstop, i_clear, i_counter};
   assign cur_cnt14 = 14'(i_counter);
   // last_q resets to all ones so the first look after reset always differs.
   assign trig_evt  = i_force | (cur != last_q);

   always_comb begin
      cur_byte = snap_q[7:0];
      case (idx_q)
         2'd0:    cur_byte = {6'b101000, snap_q[15:14]};
         2'd1:    cur_byte = {2'b00, snap_q[13:8]};
         default: cur_byte = snap_q[7:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      pending_d = pending_q | trig_evt;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      tx_d      = o_tx_data;
      start_d   = 1'b0;
      ss_n_d    = o_ss_n;
      err_d     = o_err;
      case (state_q)
         S_IDLE: begin
            if (pending_q | trig_evt) begin
               // Freeze frame content and remember it as sent at this edge.
               state_d   = S_SETUP;
               ss_n_d    = 1'b0;
               snap_d    = {i_runstop, i_clear, cur_cnt14};
               last_d    = cur;
               pending_d = 1'b0;
               cnt_d     = '0;
               idx_d     = 2'd0;
            end
         end
         S_SETUP: begin
            if (cnt_q == CW'(SETUP_CYC - 1)) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_LOAD: begin
            if (i_ready) begin
               tx_d    = cur_byte;
               start_d = 1'b1;
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            // A done in the expiry cycle still counts as success.
            if (i_done) begin
               if (idx_q == 2'd2) begin
                  state_d = S_HOLD;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_LOAD;
               end
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            ss_n_d  = 1'b1;
            err_d   = 1'b0;
            idx_d   = 2'd0;
            cnt_d   = '0;
            state_d = S_GAP;
         end
         S_ABORT: begin
            // Forgetting what was sent makes the same content go out again.
            ss_n_d  = 1'b1;
            idx_d   = 2'd0;
            last_d  = '1;
            cnt_d   = '0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == CW'(GAP_CYC - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         last_q    <= '1;
         pending_q <= 1'b0;
         idx_q     <= 2'd0;
         cnt_q     <= '0;
         snap_q    <= '0;
         o_tx_data <= 8'h00;
         o_start   <= 1'b0;
         o_ss_n    <= 1'b1;
         o_err     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         o_tx_data <= tx_d;
         o_start   <= start_d;
         o_ss_n    <= ss_n_d;
         o_err     <= err_d;
      end
   end

   assign o_busy    = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;
   localparam int CNT_W       = 14;
   localparam int SETUP_CYC   = 2;
   localparam int GAP_CYC     = 4;
   localparam int TIMEOUT_CYC = 1024;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] i_counter;
   logic             i_runstop, i_clear, i_force, i_ready, i_done;
   logic [7:0]       o_tx_data;
   logic             o_start, o_ss_n, o_busy, o_err;
   logic [2:0]       dbg_state;

   spi_frame_sequencer #(
      .CNT_W(CNT_W), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .i_counter(i_counter), .i_runstop(i_runstop),
      .i_clear(i_clear), .i_force(i_force), .i_ready(i_ready), .i_done(i_done),
      .o_tx_data(o_tx_data), .o_start(o_start), .o_ss_n(o_ss_n), .o_busy(o_busy),
      .o_err(o_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   longint cyc = 0;
   initial forever @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired", name);
   endtask

   // ---------------- SPI master responder ----------------
   int  done_dly = 8;
   bit  ready_en = 1'b1;
   int  drop_at  = -1;
   int  m_starts = 0;
   longint t_drop = 0;

   initial begin
      int mcnt;
      bit mbusy, mdrop;
      mcnt = 0; mbusy = 1'b0; mdrop = 1'b0;
      i_done = 1'b0; i_ready = 1'b1;
      forever begin
         @(negedge clk); #1;
         i_done = 1'b0;
         if (!reset) begin
            mbusy = 1'b0;
         end else begin
            if (mbusy) begin
               mcnt--;
               if (mcnt <= 0) begin
                  mbusy = 1'b0;
                  if (!mdrop) i_done = 1'b1;
               end
            end
            if (o_start) begin
               m_starts++;
               mbusy = 1'b1;
               mcnt  = done_dly;
               mdrop = (m_starts == drop_at);
               if (mdrop) t_drop = cyc;
            end
         end
         i_ready = ready_en && !mbusy;
      end
   end

   // ---------------- frame monitor ----------------
   int mon_falls  = 0;
   int mon_starts = 0;
   int last_high  = 0;
   int first_lat  = 0;

   initial begin
      bit prev_ss, in_frame, prev_rdy;
      int nb, nd, high_run, fcnt;
      logic [23:0] fb;
      logic [7:0]  held;
      prev_ss = 1'b1; in_frame = 1'b0; prev_rdy = 1'b0;
      nb = 0; nd = 0; high_run = 0; fcnt = 0; fb = '0; held = '0;
      forever begin
         @(negedge clk); #2;
         if (!reset) begin
            in_frame = 1'b0; nb = 0; nd = 0; high_run = 0;
         end else begin
            if (prev_ss && !o_ss_n) begin
               mon_falls++; last_high = high_run;
               in_frame = 1'b1; nb = 0; nd = 0; fcnt = 0; fb = '0;
            end
            if (!prev_ss && o_ss_n) begin
               if (in_frame && nb == 3 && nd == 3) got_q.push_back(fb);
               in_frame = 1'b0; high_run = 0;
            end
            if (o_ss_n) high_run++;
            if (o_start) begin
               mon_starts++;
               if (nb == 0) first_lat = fcnt;
               chk("start_inside_frame", 32'(o_ss_n), 32'd0);
               chk("start_needs_ready", 32'(prev_rdy), 32'd1);
               held = o_tx_data;
               fb = {fb[15:0], o_tx_data};
               nb++;
            end
            if (i_done && in_frame) begin
               nd++;
               chk("tx_stable_until_done", 32'(o_tx_data), 32'(held));
            end
            if (in_frame) fcnt++;
         end
         prev_ss = o_ss_n; prev_rdy = i_ready;
      end
   end

   // ---------------- reference model ----------------
   bit          m_valid = 1'b0;
   bit          m_rs, m_cl;
   int          m_cnt;

   function automatic logic [23:0] model_frame(input bit rs, input bit cl, input int cnt);
      int b0, b1, b2;
      b0 = 160 + (rs ? 2 : 0) + (cl ? 1 : 0);
      b1 = (cnt % 16384) / 256;
      b2 = cnt % 256;
      return {8'(b0), 8'(b1), 8'(b2)};
   endfunction

   task automatic model_txn(input bit rs, input bit cl, input int cnt, input bit frc);
      if (frc || !m_valid || rs != m_rs || cl != m_cl || cnt != m_cnt)
         exp_q.push_back(model_frame(rs, cl, cnt));
      m_valid = 1'b1; m_rs = rs; m_cl = cl; m_cnt = cnt;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input bit rs, input bit cl, input logic [13:0] cnt, input bit frc);
      @(negedge clk);
      i_runstop = rs; i_clear = cl; i_counter = cnt; i_force = frc;
      @(negedge clk);
      i_force = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int streak, k;
      streak = 0; k = 0;
      while (streak < 12 && k < 5000) begin
         @(negedge clk);
         k++;
         if (!o_busy && o_ss_n) streak++;
         else streak = 0;
      end
      if (k >= 5000) fail_bound(name);
   endtask

   task automatic wait_starts(input string name, input int target);
      int k;
      k = 0;
      while (mon_starts < target && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) fail_bound(name);
   endtask

   task automatic check_frames(input string name);
      chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         chk({name, "_frame"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rs;
      bit          cl;
      logic [13:0] cnt;
      bit          frc;
      bit          send;
      logic [23:0] frame;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int f0, s0, k;
      bit rs, cl, frc;
      int cnt;

      vecs[0] = '{1'b1, 1'b1, 14'h2A5C, 1'b0, 1'b1, 24'hA32A5C};
      vecs[1] = '{1'b1, 1'b1, 14'h2A5C, 1'b0, 1'b0, 24'h000000};
      vecs[2] = '{1'b1, 1'b1, 14'h2A5C, 1'b1, 1'b1, 24'hA32A5C};
      vecs[3] = '{1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 24'hA00000};
      vecs[4] = '{1'b0, 1'b1, 14'h3FFF, 1'b0, 1'b1, 24'hA13FFF};
      vecs[5] = '{1'b1, 1'b0, 14'h3FFF, 1'b0, 1'b1, 24'hA23FFF};
      vecs[6] = '{1'b1, 1'b0, 14'h0100, 1'b0, 1'b1, 24'hA20100};
      vecs[7] = '{1'b1, 1'b0, 14'h00FF, 1'b1, 1'b1, 24'hA200FF};

      // Reset values
      reset = 1'b0; i_force = 1'b0;
      i_counter = 14'h0123; i_runstop = 1'b1; i_clear = 1'b0;
      tick(3);
      chk("rst_ss_n", 32'(o_ss_n), 32'd1);
      chk("rst_start", 32'(o_start), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_tx", 32'(o_tx_data), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);

      // First frame after reset
      reset = 1'b1;
      exp_q.push_back(24'hA20123);
      m_valid = 1'b1; m_rs = 1'b1; m_cl = 1'b0; m_cnt = 'h0123;
      @(negedge clk);
      chk("t1_ss_low", 32'(o_ss_n), 32'd0);
      wait_idle("t1_idle");
      check_frames("t1");
      chk("t1_setup_latency", 32'(first_lat), 32'(SETUP_CYC + 1));
      chk("t1_err", 32'(o_err), 32'd0);

      // Quiet while unchanged, then forced resend
      f0 = mon_falls; s0 = mon_starts;
      tick(500);
      chk("t2_no_ss", 32'(mon_falls), 32'(f0));
      chk("t2_no_start", 32'(mon_starts), 32'(s0));
      @(negedge clk); i_force = 1'b1;
      @(negedge clk); i_force = 1'b0;
      chk("t2_ss_next_edge", 32'(o_ss_n), 32'd0);
      exp_q.push_back(24'hA20123);
      wait_idle("t2_idle");
      check_frames("t2");

      // Counter changes mid-frame
      s0 = mon_starts;
      drive(1'b1, 1'b0, 14'h0123, 1'b1);
      wait_starts("t3_byte1", s0 + 2);
      i_counter = 14'h0124;
      exp_q.push_back(24'hA20123);
      exp_q.push_back(24'hA20124);
      m_cnt = 'h0124;
      wait_idle("t3_idle");
      check_frames("t3");
      chk("t3_gap_high", 32'(last_high), 32'(GAP_CYC + 1));

      // Done never returns on byte 1
      drop_at = m_starts + 2;
      drive(1'b1, 1'b0, 14'h0124, 1'b1);
      k = 0;
      while (!o_err && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) fail_bound("t4_err");
      else chk("t4_timeout_cycles", 32'(cyc - t_drop), 32'(TIMEOUT_CYC));
      tick(2);
      chk("t4_ss_high", 32'(o_ss_n), 32'd1);
      chk("t4_err_sticky", 32'(o_err), 32'd1);
      exp_q.push_back(24'hA20124);
      wait_idle("t4_idle");
      check_frames("t4");
      chk("t4_err_cleared", 32'(o_err), 32'd0);
      drop_at = -1;

      // Ready held low in LOAD
      @(negedge clk); ready_en = 1'b0;
      s0 = mon_starts;
      drive(1'b1, 1'b0, 14'h0124, 1'b1);
      tick(20);
      chk("t5_no_start", 32'(mon_starts), 32'(s0));
      chk("t5_ss_low", 32'(o_ss_n), 32'd0);
      ready_en = 1'b1;
      exp_q.push_back(24'hA20124);
      wait_idle("t5_idle");
      check_frames("t5");

      // Table-driven vectors
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].rs, vecs[i].cl, vecs[i].cnt, vecs[i].frc);
         if (vecs[i].send) exp_q.push_back(vecs[i].frame);
         m_valid = 1'b1; m_rs = vecs[i].rs; m_cl = vecs[i].cl; m_cnt = int'(vecs[i].cnt);
         wait_idle($sformatf("vec%0d_idle", i));
         check_frames($sformatf("vec%0d", i));
      end

      // Randomized transactions against the model
      for (int i = 0; i < 20; i++) begin
         done_dly = $urandom_range(1, 12);
         if ($urandom_range(0, 2) == 0) begin
            rs = m_rs; cl = m_cl; cnt = m_cnt;
         end else begin
            rs = 1'($urandom_range(0, 1));
            cl = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 16383);
         end
         frc = ($urandom_range(0, 3) == 0);
         model_txn(rs, cl, cnt, frc);
         drive(rs, cl, 14'(cnt), frc);
         wait_idle($sformatf("rand%0d_idle", i));
         check_frames($sformatf("rand%0d", i));
         chk("rand_err", 32'(o_err), 32'd0);
      end

      // Reset during the wait on byte 2
      done_dly = 8;
      s0 = mon_starts;
      drive(1'(m_rs), 1'(m_cl), 14'(m_cnt), 1'b1);
      wait_starts("t6_byte2", s0 + 3);
      tick(2);
      #3 reset = 1'b0;
      #1;
      chk("t6_ss_async", 32'(o_ss_n), 32'd1);
      chk("t6_start_async", 32'(o_start), 32'd0);
      chk("t6_busy_async", 32'(o_busy), 32'd0);
      tick(2);
      chk("t6_state_idle", 32'(dbg_state), 32'd0);
      reset = 1'b1;
      m_valid = 1'b0;
      model_txn(m_rs, m_cl, m_cnt, 1'b0);
      wait_idle("t6_idle");
      check_frames("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
